aes_key_sched_ctrl: RTL and testbench

- Sequences the existing combinational one-round key generator (`keygen`, round_num 1..10) to expand a 128-bit AES cipher key into all 11 round keys.
- Stores the round keys in an internal register file.
- Serves round keys to the encryption round datapath through a registered read port.
- Sits between key-load logic and the AES encryption core.

---
 rtl/aes_pkg.sv | 15 +
 rtl/keygen.sv | 75 +++++++
 rtl/aes_key_sched_ctrl.sv | 93 +++++++++
 tb/tb_aes_key_sched_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, key-schedule FSM encoding and round-key index type.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    // Key-schedule controller states (legacy-compatible constants)
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] EXPAND = 2'b01;
    localparam logic [1:0] FINISH = 2'b10;

    // Index into the 11-entry round-key store; also the keygen round number
    typedef logic [3:0] rk_idx_t;

endpackage

// File: rtl/keygen.sv
// One AES-128 key-expansion round: derives round key N from round key N-1.
// Purely combinational; bit 0 of each 128-bit vector is the key's MSB.
module keygen (
    input  logic [0:127] keyin,
    input  logic [3:0]   round_num,
    output logic [0:127] keyout
);

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // Round constant; out-of-range rounds yield 0 and are never used by the controller
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [0:31] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    // Word-wise expansion: temp = SubWord(RotWord(w3)) ^ Rcon, then a running XOR chain
    always_comb begin
        // NOTE: every combinational output is assigned on every path, so no latch is inferred.
        w0   = keyin[0:31];
        w1   = keyin[32:63];
        w2   = keyin[64:95];
        w3   = keyin[96:127];
        temp = {sbox(w3[8:15]), sbox(w3[16:23]), sbox(w3[24:31]), sbox(w3[0:7])}
             ^ {rcon(round_num), 24'h000000};
        n0     = w0 ^ temp;
        n1     = w1 ^ n0;
        n2     = w2 ^ n1;
        n3     = w3 ^ n2;
        keyout = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: steps keygen through rounds 1..10, one per
// cycle, stores all 11 round keys and serves them on a registered read port.
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    input  logic [0:3]   rk_addr,
    output logic [0:127] rk_out,
    output logic         busy,
    output logic         done,
    output logic         key_valid
);

    logic [1:0]             state;
    rk_idx_t                cnt;
    rk_idx_t                addr;
    logic [0:AES_KEY_W-1]   cur_key;
    logic [0:AES_KEY_W-1]   keyout;
    logic [0:AES_KEY_W-1]   rk [0:AES_NR];

    assign addr = rk_addr;

    keygen u_keygen (
        .keyin     (cur_key),
        .round_num (cnt),
        .keyout    (keyout)
    );

    // Sequencing FSM, round counter, working key and round-key store
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_key   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            // NOTE: the round-key store is cleared on reset so stale keys never leak after a reset.
            for (int i = 0; i <= AES_NR; i++) begin
                rk[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk[0]     <= key_in;
                        cur_key   <= key_in;
                        cnt       <= 4'd1;
                        key_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    rk[cnt] <= keyout;
                    cur_key <= keyout;
                    if (cnt == 4'(AES_NR)) begin
                        cnt   <= '0;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                FINISH: begin
                    done      <= 1'b1;
                    key_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered read port; old contents are returned for an entry written this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_out <= '0;
        end else if (addr <= 4'(AES_NR)) begin
            rk_out <= rk[addr];
        end else begin
            rk_out <= '0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Testbench for aes_key_sched_ctrl: FIPS-197 vectors, corner sequences and
// random keys checked against a full-schedule reference model.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   rk_addr = '0;
    logic [127:0] rk_out;
    logic         busy;
    logic         done;
    logic         key_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .rk_addr   (rk_addr),
        .rk_out    (rk_out),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid)
    );

    // FIPS-197 S-box table, entry 0 first
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [0:79] RCON = 80'h01020408102040801b36;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY2      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic [127:0] exp_rk [0:10];

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] exp;
        string        name;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = SBOX[int'(w[b*8 +: 8])*8 +: 8];
        end
        return r;
    endfunction

    // Whole-schedule reference: FIPS-197 word recurrence over w[0..43]
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {RCON[(i/4-1)*8 +: 8], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input logic [3:0] a, input logic [127:0] exp, input string name);
        rk_addr = a;
        tick();
        check(name, rk_out, exp);
    endtask

    task automatic do_start(input logic [127:0] key);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Counts edges after the start edge until done; -1 if the bound expires
    task automatic wait_done(input int already, output int cycles);
        cycles = -1;
        for (int n = already + 1; n <= 40; n++) begin
            tick();
            if (done) begin
                cycles = n;
                return;
            end
        end
    endtask

    task automatic sweep_model(input string name);
        for (int a = 0; a < 16; a++) begin
            read_check(4'(a), (a <= 10) ? exp_rk[a] : 128'h0, $sformatf("%s_rk%0d", name, a));
        end
    endtask

    initial begin
        int cyc;
        logic [127:0] rkey;

        vecs[0] = '{4'd0,  FIPS_KEY,  "fips_rk0"};
        vecs[1] = '{4'd1,  FIPS_RK1,  "fips_rk1"};
        vecs[2] = '{4'd10, FIPS_RK10, "fips_rk10"};
        vecs[3] = '{4'd11, 128'h0,    "addr11_zero"};
        vecs[4] = '{4'd12, 128'h0,    "addr12_zero"};
        vecs[5] = '{4'd13, 128'h0,    "addr13_zero"};
        vecs[6] = '{4'd14, 128'h0,    "addr14_zero"};
        vecs[7] = '{4'd15, 128'h0,    "addr15_zero"};

        // 1. Reset values
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_done", {127'h0, done}, 128'h0);
        check("rst_key_valid", {127'h0, key_valid}, 128'h0);
        check("rst_rk_out", rk_out, 128'h0);
        rst = 1'b0;
        for (int a = 0; a < 16; a++) read_check(4'(a), 128'h0, $sformatf("rst_read%0d", a));

        // 2. FIPS-197 expansion
        model_expand(FIPS_KEY);
        do_start(FIPS_KEY);
        check("fips_busy_after_start", {127'h0, busy}, 128'h1);
        check("fips_kv_after_start", {127'h0, key_valid}, 128'h0);
        wait_done(0, cyc);
        check("fips_done_latency", 128'(cyc), 128'd11);
        check("fips_kv_at_done", {127'h0, key_valid}, 128'h1);
        check("fips_busy_at_done", {127'h0, busy}, 128'h0);
        tick();
        check("fips_done_pulse_width", {127'h0, done}, 128'h0);
        check("fips_kv_holds", {127'h0, key_valid}, 128'h1);
        for (int i = 0; i < 8; i++) read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);

        // 6. Read-port sweep against the model
        sweep_model("fips_sweep");

        // 5. Re-key, with read-before-write on rk[1]
        rk_addr = 4'd1;
        do_start(KEY2);
        check("rekey_kv_drops", {127'h0, key_valid}, 128'h0);
        tick();
        check("rekey_rbw_old_rk1", rk_out, FIPS_RK1);
        tick();
        model_expand(KEY2);
        check("rekey_new_rk1", rk_out, exp_rk[1]);
        wait_done(2, cyc);
        check("rekey_done_latency", 128'(cyc), 128'd11);
        read_check(4'd10, KEY2_RK10, "rekey_rk10");
        sweep_model("rekey_sweep");

        // 3. start pulses while busy are ignored
        model_expand(FIPS_KEY);
        do_start(FIPS_KEY);
        cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 3 || n == 10) begin
                start  = 1'b1;
                key_in = KEY2;
            end
            tick();
            start = 1'b0;
            if (done) begin
                cyc = n;
                break;
            end
        end
        check("busy_start_done_latency", 128'(cyc), 128'd11);
        sweep_model("busy_start");

        // 4. Reset mid-expansion
        do_start(KEY2);
        repeat (4) begin
            tick();
            check("midrst_no_done", {127'h0, done}, 128'h0);
        end
        rst = 1'b1;
        tick();
        check("midrst_busy", {127'h0, busy}, 128'h0);
        check("midrst_done", {127'h0, done}, 128'h0);
        check("midrst_kv", {127'h0, key_valid}, 128'h0);
        check("midrst_rk_out", rk_out, 128'h0);
        rst = 1'b0;
        for (int a = 0; a <= 4; a++) read_check(4'(a), 128'h0, $sformatf("midrst_rk%0d", a));
        check("midrst_still_no_done", {127'h0, done}, 128'h0);
        do_start(FIPS_KEY);
        wait_done(0, cyc);
        check("midrst_restart_latency", 128'(cyc), 128'd11);
        read_check(4'd10, FIPS_RK10, "midrst_restart_rk10");

        // Random keys against the reference model
        for (int k = 0; k < 4; k++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rkey);
            do_start(rkey);
            wait_done(0, cyc);
            check($sformatf("rand%0d_latency", k), 128'(cyc), 128'd11);
            for (int j = 0; j < 8; j++) begin
                int a;
                a = $urandom_range(0, 15);
                read_check(4'(a), (a <= 10) ? exp_rk[a] : 128'h0, $sformatf("rand%0d_rk%0d", k, a));
            end
            read_check(4'd10, exp_rk[10], $sformatf("rand%0d_rk10", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
